// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maze_pkg
// Description : Shared colours, move-direction encoding and move FSM states
//               for the maze renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

  // 12-bit RGB (4:4:4) colours
  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_WHITE = 12'hFFF;
  localparam logic [11:0] C_RED   = 12'hF00;
  localparam logic [11:0] C_GREEN = 12'h0F0;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } move_state_e;

endpackage
`default_nettype wire

// File: rtl/maze_move_fsm.sv
`default_nettype none
// ============================================================================
// Module      : maze_move_fsm
// Description : Move handshake, boundary/wall collision check, player
//               position and sticky win flag.
// Revision    : 1.0 - initial release
// ============================================================================
module maze_move_fsm
  import maze_pkg::*;
#(
  parameter int ROWS      = 15,
  parameter int COLS      = 15,
  parameter int RW        = $clog2(ROWS),
  parameter int CW        = $clog2(COLS),
  parameter int START_ROW = 0,
  parameter int START_COL = 0,
  parameter int GOAL_ROW  = ROWS - 1,
  parameter int GOAL_COL  = COLS - 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            move_valid_i,
  input  logic [1:0]      move_dir_i,
  input  logic [COLS-1:0] wall_i [ROWS],
  output logic            move_ready_o,
  output logic            move_done_o,
  output logic            move_blocked_o,
  output logic [RW-1:0]   player_row_o,
  output logic [CW-1:0]   player_col_o,
  output logic            win_o
);

  move_state_e   state_q;
  dir_e          dir_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          win_q;
  logic          ready_q;
  logic          done_q;
  logic          blocked_q;

  logic [RW-1:0] tgt_row_d;
  logic [CW-1:0] tgt_col_d;
  logic          off_grid;
  logic          hit_wall;
  logic          goal_hit;

  // Target cell for the latched direction; off-grid leaves target = current
  // cell so the wall lookup always stays inside the map.
  always_comb begin
    tgt_row_d = row_q;
    tgt_col_d = col_q;
    off_grid  = 1'b0;
    case (dir_q)
      DIR_UP: begin
        if (row_q == '0) off_grid = 1'b1;
        else             tgt_row_d = row_q - 1'b1;
      end
      DIR_DOWN: begin
        if (row_q == RW'(ROWS - 1)) off_grid = 1'b1;
        else                        tgt_row_d = row_q + 1'b1;
      end
      DIR_LEFT: begin
        if (col_q == '0) off_grid = 1'b1;
        else             tgt_col_d = col_q - 1'b1;
      end
      default: begin
        if (col_q == CW'(COLS - 1)) off_grid = 1'b1;
        else                        tgt_col_d = col_q + 1'b1;
      end
    endcase
    hit_wall = wall_i[tgt_row_d][tgt_col_d];
    goal_hit = (tgt_row_d == RW'(GOAL_ROW)) && (tgt_col_d == CW'(GOAL_COL));
  end

  // Move FSM: accept in IDLE, resolve in CHECK, registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      row_q     <= RW'(START_ROW);
      col_q     <= CW'(START_COL);
      win_q     <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (move_valid_i && ready_q) begin
            dir_q   <= dir_e'(move_dir_i);
            ready_q <= 1'b0;
            state_q <= ST_CHECK;
          end else begin
            ready_q <= ~win_q;
          end
        end
        default: begin
          if (off_grid || hit_wall) begin
            blocked_q <= 1'b1;
            ready_q   <= ~win_q;
          end else begin
            row_q   <= tgt_row_d;
            col_q   <= tgt_col_d;
            done_q  <= 1'b1;
            win_q   <= win_q | goal_hit;
            ready_q <= ~(win_q | goal_hit);
          end
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign move_ready_o   = ready_q;
  assign move_done_o    = done_q;
  assign move_blocked_o = blocked_q;
  assign player_row_o   = row_q;
  assign player_col_o   = col_q;
  assign win_o          = win_q;

endmodule
`default_nettype wire

// File: rtl/maze_renderer.sv
`default_nettype none
// ============================================================================
// Module      : maze_renderer
// Description : Maze display and player-movement engine. Holds the wall map,
//               drives the move FSM and colours pixels through a two-stage
//               registered pipeline (rgb lags hCount/vCount/bright by 2).
// Revision    : 1.0 - initial release
// ============================================================================
module maze_renderer
  import maze_pkg::*;
#(
  parameter int ROWS       = 15,
  parameter int COLS       = 15,
  parameter int CELL_SHIFT = 3,
  parameter int X0         = 200,
  parameter int Y0         = 100,
  parameter int START_ROW  = 0,
  parameter int START_COL  = 0,
  parameter int GOAL_ROW   = ROWS - 1,
  parameter int GOAL_COL   = COLS - 1,
  localparam int RW        = $clog2(ROWS),
  localparam int CW        = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            bright,
  input  logic [9:0]      hCount,
  input  logic [9:0]      vCount,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            move_valid,
  input  logic [1:0]      move_dir,
  output logic            move_ready,
  output logic            move_done,
  output logic            move_blocked,
  output logic [RW-1:0]   player_row,
  output logic [CW-1:0]   player_col,
  output logic            win,
  output logic [11:0]     rgb
);

  localparam int X_END = X0 + (COLS << CELL_SHIFT);
  localparam int Y_END = Y0 + (ROWS << CELL_SHIFT);

  logic [COLS-1:0] wall_q [ROWS];

  // Wall map: all walls on reset, one row written per wr_en, bad rows dropped
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) wall_q[r] <= '1;
    end else if (wr_en && ({1'b0, wr_row} < (RW + 1)'(ROWS))) begin
      wall_q[wr_row] <= wr_data;
    end
  end

  maze_move_fsm #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .RW        (RW),
    .CW        (CW),
    .START_ROW (START_ROW),
    .START_COL (START_COL),
    .GOAL_ROW  (GOAL_ROW),
    .GOAL_COL  (GOAL_COL)
  ) u_move (
    .clk            (clk),
    .reset_n        (reset_n),
    .move_valid_i   (move_valid),
    .move_dir_i     (move_dir),
    .wall_i         (wall_q),
    .move_ready_o   (move_ready),
    .move_done_o    (move_done),
    .move_blocked_o (move_blocked),
    .player_row_o   (player_row),
    .player_col_o   (player_col),
    .win_o          (win)
  );

  logic [10:0]   hx;
  logic [10:0]   vy;
  logic [9:0]    dx;
  logic [9:0]    dy;
  logic          in_maze_d;
  logic [RW-1:0] s1_row_d;
  logic [CW-1:0] s1_col_d;

  // Stage 1 decode: maze window test and cell coordinates (zeroed outside)
  always_comb begin
    hx        = {1'b0, hCount};
    vy        = {1'b0, vCount};
    dx        = hCount - 10'(X0);
    dy        = vCount - 10'(Y0);
    in_maze_d = (hx >= 11'(X0)) && (hx < 11'(X_END)) &&
                (vy >= 11'(Y0)) && (vy < 11'(Y_END));
    s1_row_d  = in_maze_d ? RW'(dy >> CELL_SHIFT) : '0;
    s1_col_d  = in_maze_d ? CW'(dx >> CELL_SHIFT) : '0;
  end

  logic          s1_in_q;
  logic          s1_bright_q;
  logic [RW-1:0] s1_row_q;
  logic [CW-1:0] s1_col_q;

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_in_q     <= 1'b0;
      s1_bright_q <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
    end else begin
      s1_in_q     <= in_maze_d;
      s1_bright_q <= bright;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
    end
  end

  logic [11:0] rgb_q;

  // Stage 2: colour priority blank > outside > player > goal > wall > path
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgb_q <= C_BLACK;
    end else if (!s1_bright_q) begin
      rgb_q <= C_BLACK;
    end else if (!s1_in_q) begin
      rgb_q <= C_WHITE;
    end else if ((s1_row_q == player_row) && (s1_col_q == player_col)) begin
      rgb_q <= C_RED;
    end else if ((s1_row_q == RW'(GOAL_ROW)) && (s1_col_q == CW'(GOAL_COL))) begin
      rgb_q <= C_GREEN;
    end else if (wall_q[s1_row_q][s1_col_q]) begin
      rgb_q <= C_BLACK;
    end else begin
      rgb_q <= C_WHITE;
    end
  end

  assign rgb = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_maze_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_renderer
// Description : Scoreboard bench for maze_renderer: expected move results and
//               pixel colours are queued at drive time and checked when the
//               DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_renderer;

  localparam int ROWS = 15;
  localparam int COLS = 15;
  localparam int X0   = 200;
  localparam int Y0   = 100;
  localparam int CS   = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bright = 1'b0;
  logic [9:0]  hCount = '0;
  logic [9:0]  vCount = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_row = '0;
  logic [14:0] wr_data = '0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = '0;
  logic        move_ready, move_done, move_blocked, win;
  logic [3:0]  player_row, player_col;
  logic [11:0] rgb;

  maze_renderer dut (
    .clk(clk), .reset_n(reset_n), .bright(bright),
    .hCount(hCount), .vCount(vCount),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .move_valid(move_valid), .move_dir(move_dir),
    .move_ready(move_ready), .move_done(move_done), .move_blocked(move_blocked),
    .player_row(player_row), .player_col(player_col),
    .win(win), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [14:0] m_map [ROWS];
  int          pr, pc;
  bit          mwin;

  typedef struct { bit blk; int r; int c; } mv_t;
  typedef struct { int due; logic [11:0] exp; } px_t;
  mv_t mv_q[$];
  px_t px_q[$];

  function automatic logic [11:0] pix_exp(input int h, input int v, input bit b);
    int r, c;
    if (!b) return 12'h000;
    if (h < X0 || h >= X0 + COLS*CS || v < Y0 || v >= Y0 + ROWS*CS) return 12'hFFF;
    r = (v - Y0) / CS;
    c = (h - X0) / CS;
    if (r == pr && c == pc) return 12'hF00;
    if (r == ROWS-1 && c == COLS-1) return 12'h0F0;
    return m_map[r][c] ? 12'h000 : 12'hFFF;
  endfunction

  // Move monitor: every pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (reset_n && (move_done || move_blocked)) begin
      if (mv_q.size() == 0) begin
        chk("unexp_pulse", 32'(move_done | move_blocked), 32'd0);
      end else begin
        mv_t e;
        e = mv_q.pop_front();
        chk("mv_blocked", 32'(move_blocked), 32'(e.blk));
        chk("mv_done", 32'(move_done), 32'(!e.blk));
        chk("mv_row", 32'(player_row), 32'(e.r));
        chk("mv_col", 32'(player_col), 32'(e.c));
      end
    end
  end

  // Pixel monitor: compare rgb on the cycle each queued pixel falls due
  always @(negedge clk) begin
    if (px_q.size() > 0 && px_q[0].due == cyc) begin
      px_t p;
      p = px_q.pop_front();
      chk("pix", 32'(rgb), 32'(p.exp));
    end
  end

  task automatic write_row(input int row, input logic [14:0] data);
    wr_en = 1'b1; wr_row = 4'(row); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_map[row] = data;
    @(negedge clk); #1;
  endtask

  // Issue one move; optionally write a map row on the CHECK edge
  task automatic do_move(input logic [1:0] d, input bit wr, input int wrow, input logic [14:0] wdata);
    int  n;
    int  tr, tc;
    bit  off;
    mv_t e;
    n = 0;
    while (!move_ready && n < 8) begin @(negedge clk); #1; n++; end
    chk("rdy_wait", 32'(move_ready), 32'd1);
    tr = pr; tc = pc; off = 0;
    case (d)
      2'b00: if (pr == 0)      off = 1; else tr = pr - 1;
      2'b01: if (pr == ROWS-1) off = 1; else tr = pr + 1;
      2'b10: if (pc == 0)      off = 1; else tc = pc - 1;
      default: if (pc == COLS-1) off = 1; else tc = pc + 1;
    endcase
    e.blk = off || m_map[tr][tc];
    if (!e.blk) begin pr = tr; pc = tc; end
    e.r = pr; e.c = pc;
    mv_q.push_back(e);
    move_valid = 1'b1; move_dir = d;
    @(posedge clk); #1;
    move_valid = 1'b0;
    if (wr) begin wr_en = 1'b1; wr_row = 4'(wrow); wr_data = wdata; end
    @(negedge clk); #1;
    chk("rdy_low", 32'(move_ready), 32'd0);
    @(posedge clk); #1;
    if (wr) begin wr_en = 1'b0; m_map[wrow] = wdata; end
    if (pr == ROWS-1 && pc == COLS-1) mwin = 1;
    @(negedge clk); #1;
    chk("rdy_back", 32'(move_ready), 32'(!mwin));
    chk("mv_pending", 32'(mv_q.size()), 32'd0);
  endtask

  task automatic pix(input int h, input int v, input bit b);
    px_t p;
    @(posedge clk); #1;
    hCount = 10'(h); vCount = 10'(v); bright = b;
    p.due = cyc + 2;
    p.exp = pix_exp(h, v, b);
    px_q.push_back(p);
  endtask

  task automatic pix_drain();
    repeat (3) @(negedge clk);
    #1;
    chk("pix_drain", 32'(px_q.size()), 32'd0);
  endtask

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < ROWS; r++) m_map[r] = '1;
    pr = 0; pc = 0; mwin = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(move_ready), 32'd0);
    chk("rst_win", 32'(win), 32'd0);
    chk("rst_row", 32'(player_row), 32'd0);
    chk("rst_col", 32'(player_col), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'h000);
    chk("rst_pulse", 32'(move_done | move_blocked), 32'd0);
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk("ready_after_rst", 32'(move_ready), 32'd1);

    // Pixels on the all-wall map
    pix(X0, Y0, 1);                         // player RED
    pix(X0 + CS, Y0, 1);                    // wall BLACK
    pix(X0 + COLS*CS - 1, Y0 + ROWS*CS - 1, 1); // goal GREEN
    pix(X0 - 1, Y0, 1);                     // left of maze WHITE
    pix(X0 + COLS*CS, Y0, 1);               // right edge WHITE
    pix(X0, Y0 + ROWS*CS, 1);               // below maze WHITE
    pix(X0, Y0 - 1, 1);                     // above maze WHITE
    pix(X0, Y0, 0);                         // blanked BLACK
    pix(X0 + 7, Y0 + 7, 1);                 // last pixel of player cell RED
    pix_drain();

    // Wall and off-grid blocks
    write_row(0, 15'h7FFE);
    do_move(2'b11, 0, 0, '0);               // right into wall: blocked
    do_move(2'b00, 0, 0, '0);               // up off-grid: blocked
    do_move(2'b10, 0, 0, '0);               // left off-grid: blocked
    chk("pos_r_00", 32'(player_row), 32'd0);
    chk("pos_c_00", 32'(player_col), 32'd0);

    // Open column 0 of row 1 and step down
    write_row(1, 15'h7FFE);
    do_move(2'b01, 0, 0, '0);
    chk("pos_r_10", 32'(player_row), 32'd1);
    chk("pos_c_10", 32'(player_col), 32'd0);

    pix(X0, Y0 + CS, 1);                    // player now at (1,0)
    pix(X0, Y0, 1);                         // vacated open cell WHITE
    pix(X0 + CS, Y0 + CS, 1);               // wall BLACK
    pix_drain();

    // Write clearing the target on the CHECK edge: check sees old wall
    do_move(2'b01, 1, 2, 15'h0000);
    do_move(2'b01, 0, 0, '0);
    chk("pos_r_20", 32'(player_row), 32'd2);

    // Out-of-range row write is ignored
    write_row(15, 15'h0000);

    // Clear map, walk to the goal
    for (int r = 0; r < ROWS; r++) write_row(r, 15'h0000);
    while (pr < ROWS-1) do_move(2'b01, 0, 0, '0);
    chk("win_before", 32'(win), 32'd0);
    while (pc < COLS-1) do_move(2'b11, 0, 0, '0);
    chk("win", 32'(win), 32'd1);
    chk("pos_r_goal", 32'(player_row), 32'd14);
    chk("pos_c_goal", 32'(player_col), 32'd14);

    // After win: requests are never accepted
    move_valid = 1'b1; move_dir = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("ready_won", 32'(move_ready), 32'd0);
    end
    move_valid = 1'b0;
    chk("pos_r_hold", 32'(player_row), 32'd14);
    chk("pos_c_hold", 32'(player_col), 32'd14);
    chk("win_hold", 32'(win), 32'd1);

    // Pixels on the cleared map, player on the goal
    pix(X0 + COLS*CS - 1, Y0 + ROWS*CS - 1, 1); // player beats goal: RED
    pix(X0, Y0, 1);                         // open path WHITE
    pix(X0 + 60, Y0 + 60, 1);               // open path WHITE
    pix(X0 + 60, Y0 + 60, 0);               // blanked BLACK
    pix(X0 - 1, Y0 + 60, 1);                // outside WHITE
    pix_drain();

    chk("mv_q_empty", 32'(mv_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
